calendar_counter: RTL and testbench

CALENDAR_COUNTER -- requirements
Module: calendar_counter

---
 rtl/calendar_counter.sv | 188 ++++++++++++++++++
 tb/tb_calendar_counter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/calendar_counter.sv
// Binary calendar/clock advanced once per clk1sec edge, with a level-held load
// request acknowledged through a two-state handshake and range clamping on load.
module calendar_counter #(
    parameter logic [7:0] RST_YEAR  = 8'd24,
    parameter logic [7:0] RST_MONTH = 8'd1,
    parameter logic [7:0] RST_DAY   = 8'd1
) (
    input  logic        clk1sec,
    input  logic        rst,
    input  logic [47:0] bin_time,
    input  logic        en_time,
    output logic [7:0]  year,
    output logic [7:0]  month,
    output logic [7:0]  day,
    output logic [7:0]  hour,
    output logic [7:0]  minute,
    output logic [7:0]  second,
    output logic        load_ack,
    output logic        day_tick,
    output logic        load_err
);

    // Handshake: en_time and load_ack form a level request/acknowledge pair.
    // A load happens only on the IDLE->ACK transition; load_ack mirrors the
    // FSM state, so it doubles as the state observation point.
    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] year_q, month_q, day_q, hour_q, minute_q, second_q;
    logic [7:0] year_d, month_d, day_d, hour_d, minute_d, second_d;
    logic       tick_q, tick_d;
    logic       err_q, err_d;
    logic       load;

    logic [7:0] ld_year, ld_month, ld_day, ld_hour, ld_minute, ld_second;
    logic [7:0] ld_dim, cur_dim;
    logic       ld_err;

    function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [7:0] y);
        logic leap;
        leap = (y[1:0] == 2'b00) && (y != 8'd100) && (y != 8'd200);
        case (m)
            8'd4, 8'd6, 8'd9, 8'd11: days_in_month = 8'd30;
            8'd2:                    days_in_month = leap ? 8'd29 : 8'd28;
            default:                 days_in_month = 8'd31;
        endcase
    endfunction

    // Clamp order matters: the day limit depends on the already-clamped month.
    always_comb begin
        ld_year   = bin_time[47:40];
        ld_month  = bin_time[39:32];
        ld_day    = bin_time[31:24];
        ld_hour   = bin_time[23:16];
        ld_minute = bin_time[15:8];
        ld_second = bin_time[7:0];
        ld_err    = 1'b0;
        if (ld_month == 8'd0) begin
            ld_month = 8'd1;
            ld_err   = 1'b1;
        end else if (ld_month > 8'd12) begin
            ld_month = 8'd12;
            ld_err   = 1'b1;
        end
        ld_dim = days_in_month(ld_month, ld_year);
        if (ld_day == 8'd0) begin
            ld_day = 8'd1;
            ld_err = 1'b1;
        end else if (ld_day > ld_dim) begin
            ld_day = ld_dim;
            ld_err = 1'b1;
        end
        if (ld_hour > 8'd23) begin
            ld_hour = 8'd23;
            ld_err  = 1'b1;
        end
        if (ld_minute > 8'd59) begin
            ld_minute = 8'd59;
            ld_err    = 1'b1;
        end
        if (ld_second > 8'd59) begin
            ld_second = 8'd59;
            ld_err    = 1'b1;
        end
    end

    assign cur_dim = days_in_month(month_q, year_q);

    always_comb begin
        state_d  = state_q;
        year_d   = year_q;
        month_d  = month_q;
        day_d    = day_q;
        hour_d   = hour_q;
        minute_d = minute_q;
        second_d = second_q;
        tick_d   = 1'b0;
        err_d    = err_q;
        load     = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_time) begin
                    load    = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!en_time) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            year_d   = ld_year;
            month_d  = ld_month;
            day_d    = ld_day;
            hour_d   = ld_hour;
            minute_d = ld_minute;
            second_d = ld_second;
            err_d    = ld_err;
        end else if (second_q < 8'd59) begin
            second_d = second_q + 8'd1;
        end else begin
            second_d = 8'd0;
            if (minute_q < 8'd59) begin
                minute_d = minute_q + 8'd1;
            end else begin
                minute_d = 8'd0;
                if (hour_q < 8'd23) begin
                    hour_d = hour_q + 8'd1;
                end else begin
                    hour_d = 8'd0;
                    tick_d = 1'b1;
                    if (day_q < cur_dim) begin
                        day_d = day_q + 8'd1;
                    end else begin
                        day_d = 8'd1;
                        if (month_q < 8'd12) begin
                            month_d = month_q + 8'd1;
                        end else begin
                            month_d = 8'd1;
                            year_d  = year_q + 8'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk1sec or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            year_q   <= RST_YEAR;
            month_q  <= RST_MONTH;
            day_q    <= RST_DAY;
            hour_q   <= 8'd0;
            minute_q <= 8'd0;
            second_q <= 8'd0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            year_q   <= year_d;
            month_q  <= month_d;
            day_q    <= day_d;
            hour_q   <= hour_d;
            minute_q <= minute_d;
            second_q <= second_d;
            tick_q   <= tick_d;
            err_q    <= err_d;
        end
    end

    assign year     = year_q;
    assign month    = month_q;
    assign day      = day_q;
    assign hour     = hour_q;
    assign minute   = minute_q;
    assign second   = second_q;
    assign load_ack = (state_q == ACK);
    assign day_tick = tick_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_calendar_counter.sv
// Bench for calendar_counter: seconds-of-day/date model checked every cycle,
// plus directed loads with hand-computed literal expectations.
module tb_calendar_counter;

  logic        clk1sec = 1'b0;
  logic        rst = 1'b0;
  logic [47:0] bin_time = '0;
  logic        en_time = 1'b0;
  logic [7:0]  year, month, day, hour, minute, second;
  logic        load_ack, day_tick, load_err;

  int n_vec = 0;
  int n_err = 0;

  calendar_counter dut (
    .clk1sec  (clk1sec),
    .rst      (rst),
    .bin_time (bin_time),
    .en_time  (en_time),
    .year     (year),
    .month    (month),
    .day      (day),
    .hour     (hour),
    .minute   (minute),
    .second   (second),
    .load_ack (load_ack),
    .day_tick (day_tick),
    .load_err (load_err)
  );

  always #5 clk1sec = ~clk1sec;

  // Model: date as year/month/day, time as seconds since midnight.
  int m_year = 24, m_month = 1, m_day = 1, m_sod = 0;
  bit m_ack = 0, m_tick = 0, m_err = 0;

  function automatic int dim(input int m, input int y);
    int tbl[13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && (y % 4 == 0) && y != 100 && y != 200) return 29;
    return tbl[m];
  endfunction

  task automatic model_reset();
    m_year = 24; m_month = 1; m_day = 1; m_sod = 0;
    m_ack = 0; m_tick = 0; m_err = 0;
  endtask

  task automatic model_step();
    int y, mo, d, h, mi, s;
    if (!m_ack && en_time) begin
      y = bin_time[47:40]; mo = bin_time[39:32]; d = bin_time[31:24];
      h = bin_time[23:16]; mi = bin_time[15:8]; s = bin_time[7:0];
      m_err = 0;
      if (mo < 1 || mo > 12) begin m_err = 1; mo = (mo < 1) ? 1 : 12; end
      if (d < 1 || d > dim(mo, y)) begin m_err = 1; d = (d < 1) ? 1 : dim(mo, y); end
      if (h > 23) begin m_err = 1; h = 23; end
      if (mi > 59) begin m_err = 1; mi = 59; end
      if (s > 59) begin m_err = 1; s = 59; end
      m_year = y; m_month = mo; m_day = d; m_sod = h * 3600 + mi * 60 + s;
      m_ack = 1; m_tick = 0;
    end else begin
      if (m_ack && !en_time) m_ack = 0;
      m_sod = m_sod + 1;
      m_tick = 0;
      if (m_sod == 86400) begin
        m_sod = 0; m_tick = 1;
        m_day = m_day + 1;
        if (m_day > dim(m_month, m_year)) begin
          m_day = 1; m_month = m_month + 1;
          if (m_month > 12) begin m_month = 1; m_year = (m_year + 1) % 256; end
        end
      end
    end
  endtask

  always @(posedge clk1sec or negedge rst) begin
    if (!rst) model_reset();
    else model_step();
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk1sec) begin
    check("mdl_year", year, 8'(m_year));
    check("mdl_month", month, 8'(m_month));
    check("mdl_day", day, 8'(m_day));
    check("mdl_hour", hour, 8'(m_sod / 3600));
    check("mdl_minute", minute, 8'((m_sod / 60) % 60));
    check("mdl_second", second, 8'(m_sod % 60));
    check("mdl_load_ack", {7'd0, load_ack}, {7'd0, m_ack});
    check("mdl_day_tick", {7'd0, day_tick}, {7'd0, m_tick});
    check("mdl_load_err", {7'd0, load_err}, {7'd0, m_err});
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk1sec);
  endtask

  task automatic lit(input string name, input int y, input int mo, input int d,
                     input int h, input int mi, input int s);
    check({name, "_year"}, year, 8'(y));
    check({name, "_month"}, month, 8'(mo));
    check({name, "_day"}, day, 8'(d));
    check({name, "_hour"}, hour, 8'(h));
    check({name, "_minute"}, minute, 8'(mi));
    check({name, "_second"}, second, 8'(s));
  endtask

  task automatic lit_flags(input string name, input bit ack, input bit tk, input bit err);
    check({name, "_ack"}, {7'd0, load_ack}, {7'd0, ack});
    check({name, "_tick"}, {7'd0, day_tick}, {7'd0, tk});
    check({name, "_err"}, {7'd0, load_err}, {7'd0, err});
  endtask

  // One-edge load: request seen at the next edge, then dropped.
  task automatic do_load(input int y, input int mo, input int d, input int h,
                         input int mi, input int s);
    bin_time = {8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
    en_time = 1'b1;
    tick();
    en_time = 1'b0;
  endtask

  initial begin
    tick(2);
    lit("rst_hold", 24, 1, 1, 0, 0, 0);
    lit_flags("rst_hold", 0, 0, 0);
    rst = 1'b1;
    tick(61);
    lit("count61", 24, 1, 1, 0, 1, 1);
    lit_flags("count61", 0, 0, 0);

    do_load(24, 2, 28, 23, 59, 59);
    tick();
    lit("leap24", 24, 2, 29, 0, 0, 0);
    lit_flags("leap24", 0, 1, 0);
    tick();
    lit_flags("leap24_after", 0, 0, 0);

    do_load(23, 2, 28, 23, 59, 59);
    tick();
    lit("nonleap23", 23, 3, 1, 0, 0, 0);

    do_load(100, 2, 28, 23, 59, 59);
    tick();
    lit("cent100", 100, 3, 1, 0, 0, 0);

    do_load(0, 2, 28, 23, 59, 59);
    tick();
    lit("cent0", 0, 2, 29, 0, 0, 0);

    do_load(24, 4, 30, 23, 59, 59);
    tick();
    lit("apr30", 24, 5, 1, 0, 0, 0);

    do_load(255, 12, 31, 23, 59, 59);
    tick();
    lit("ywrap", 0, 1, 1, 0, 0, 0);
    lit_flags("ywrap", 0, 1, 0);
    tick();
    lit_flags("ywrap_after", 0, 0, 0);

    do_load(24, 13, 40, 30, 70, 99);
    lit("clamp", 24, 12, 31, 23, 59, 59);
    lit_flags("clamp", 1, 0, 1);
    tick();
    do_load(23, 2, 30, 5, 6, 7);
    lit("clampfeb", 23, 2, 28, 5, 6, 7);
    lit_flags("clampfeb", 1, 0, 1);
    tick();
    do_load(24, 6, 15, 12, 0, 0);
    lit("valid", 24, 6, 15, 12, 0, 0);
    lit_flags("valid", 1, 0, 0);
    tick();
    do_load(0, 0, 0, 0, 0, 0);
    lit("zeroclamp", 0, 1, 1, 0, 0, 0);
    lit_flags("zeroclamp", 1, 0, 1);
    tick();

    bin_time = {8'd24, 8'd5, 8'd5, 8'd10, 8'd0, 8'd0};
    en_time = 1'b1;
    tick();
    lit("hs1", 24, 5, 5, 10, 0, 0);
    lit_flags("hs1", 1, 0, 0);
    tick();
    lit("hs2", 24, 5, 5, 10, 0, 1);
    tick();
    lit("hs3", 24, 5, 5, 10, 0, 2);
    lit_flags("hs3", 1, 0, 0);
    en_time = 1'b0;
    tick();
    lit("hs_drop", 24, 5, 5, 10, 0, 3);
    lit_flags("hs_drop", 0, 0, 0);

    bin_time = {8'd30, 8'd7, 8'd4, 8'd8, 8'd9, 8'd10};
    en_time = 1'b1;
    tick();
    lit_flags("ack_pre_rst", 1, 0, 0);
    #2 rst = 1'b0;
    #1;
    lit("rst_mid", 24, 1, 1, 0, 0, 0);
    lit_flags("rst_mid", 0, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    lit("reload", 30, 7, 4, 8, 9, 10);
    lit_flags("reload", 1, 0, 0);
    en_time = 1'b0;
    tick(2);
    lit("reload_run", 30, 7, 4, 8, 9, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
